// File: rtl/comb_mask_generator_if.sv
// ============================================================================
// comb_mask_generator_if : mask stream bundle (valid/ready with index/last).
// Revision: 1.0
// ============================================================================
`default_nettype none

interface comb_mask_generator_if #(
  parameter int SIZE = 5,
  parameter int CW   = 16
);
  logic            m_valid;
  logic            m_ready;
  logic [SIZE-1:0] m_mask;
  logic [CW-1:0]   m_index;
  logic            m_last;

  modport master (output m_valid, output m_mask, output m_index, output m_last, input m_ready);
  modport slave  (input m_valid, input m_mask, input m_index, input m_last, output m_ready);
endinterface

`default_nettype wire

// File: rtl/comb_mask_generator.sv
// ============================================================================
// comb_mask_generator : enumerates every SIZE-bit mask with r bits set, ascending.
// Revision: 1.0
// ============================================================================
`default_nettype none

module comb_mask_generator #(
  parameter int SIZE = 5,
  parameter int RW   = 3,
  parameter int CW   = 16
) (
  input  wire logic          clk,
  input  wire logic          rst,
  input  wire logic          start,
  input  wire logic [RW-1:0] r,
  output logic               busy,
  comb_mask_generator_if.master m,
  output logic               done,
  output logic               err
);

  localparam int CTZW = (SIZE > 1) ? $clog2(SIZE) : 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t          r_state;
  logic [RW-1:0]   r_r;
  logic [SIZE-1:0] r_mask;
  logic [CW-1:0]   r_index;
  logic            r_valid;
  logic            r_last;
  logic            r_busy;
  logic            r_done;
  logic            r_err;

  logic [SIZE-1:0] w_c;
  logic [SIZE:0]   w_s;
  logic [CTZW-1:0] w_ctz;
  logic [SIZE-1:0] w_diff;
  logic [SIZE-1:0] w_next;
  logic [SIZE-1:0] w_load_first;
  logic [SIZE-1:0] w_load_final;
  logic [SIZE-1:0] w_final;

  function automatic logic [SIZE-1:0] first_mask(input logic [RW-1:0] rv);
    logic [SIZE-1:0] f;
    for (int i = 0; i < SIZE; i++) f[i] = (i < int'(rv));
    return f;
  endfunction

  function automatic logic [SIZE-1:0] final_mask(input logic [RW-1:0] rv);
    logic [SIZE-1:0] f;
    for (int i = 0; i < SIZE; i++) f[i] = (i >= SIZE - int'(rv));
    return f;
  endfunction

  // Gosper's hack: lowest set bit c, ripple it up, refill the low ones shifted by ctz(c)
  always_comb begin
    w_c   = r_mask & (~r_mask + SIZE'(1));
    w_s   = {1'b0, r_mask} + {1'b0, w_c};
    w_ctz = '0;
    for (int i = SIZE - 1; i >= 0; i--) begin
      if (w_c[i]) w_ctz = CTZW'(i);
    end
    w_diff = SIZE'(((w_s ^ {1'b0, r_mask}) >> 2) >> w_ctz);
    w_next = w_s[SIZE-1:0] | w_diff;
  end

  assign w_load_first = first_mask(r);
  assign w_load_final = final_mask(r);
  assign w_final      = final_mask(r_r);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_r     <= '0;
      r_mask  <= '0;
      r_index <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            if (int'(r) > SIZE) begin
              r_err <= 1'b1;
            end else begin
              r_r     <= r;
              r_mask  <= w_load_first;
              r_index <= '0;
              r_last  <= (w_load_first == w_load_final);
              r_valid <= 1'b1;
              r_busy  <= 1'b1;
              r_state <= EMIT;
            end
          end
        end
        EMIT: begin
          if (m.m_ready) begin
            if (r_last) begin
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_last  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= IDLE;
            end else begin
              r_mask  <= w_next;
              r_index <= r_index + CW'(1);
              r_last  <= (w_next == w_final);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign m.m_valid = r_valid;
  assign m.m_mask  = r_mask;
  assign m.m_index = r_index;
  assign m.m_last  = r_last;

endmodule

`default_nettype wire

// File: tb/tb_comb_mask_generator.sv
// ============================================================================
// tb_comb_mask_generator : scoreboard bench for the combination mask stream.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_comb_mask_generator;

  localparam int SIZE = 5;
  localparam int RW   = 3;
  localparam int CW   = 16;

  typedef struct packed {
    logic [SIZE-1:0] mask;
    logic [CW-1:0]   idx;
    logic            last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [RW-1:0] r;
  logic          busy;
  logic          done;
  logic          err;

  comb_mask_generator_if #(.SIZE(SIZE), .CW(CW)) m_if ();

  comb_mask_generator #(.SIZE(SIZE), .RW(RW), .CW(CW)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .r     (r),
    .busy  (busy),
    .m     (m_if),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  int    total = 0;
  int    bad   = 0;
  beat_t q[$];

  logic [SIZE-1:0] exp3 [10] = '{5'b00111, 5'b01011, 5'b01101, 5'b01110, 5'b10011,
                                 5'b10101, 5'b10110, 5'b11001, 5'b11010, 5'b11100};
  logic [SIZE-1:0] exp2 [10] = '{5'b00011, 5'b00101, 5'b00110, 5'b01001, 5'b01010,
                                 5'b01100, 5'b10001, 5'b10010, 5'b10100, 5'b11000};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops one expectation per accepted beat; also checks hold-while-stalled.
  logic            prev_hold = 1'b0;
  logic [SIZE-1:0] held_mask;
  logic [CW-1:0]   held_idx;

  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (prev_hold && m_if.m_valid) begin
        chk("hold_mask", 32'(m_if.m_mask), 32'(held_mask));
        chk("hold_index", 32'(m_if.m_index), 32'(held_idx));
      end
      prev_hold = m_if.m_valid && !m_if.m_ready;
      held_mask = m_if.m_mask;
      held_idx  = m_if.m_index;
      if (m_if.m_valid && m_if.m_ready) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got mask %b index %0d expected none", m_if.m_mask, m_if.m_index);
        end else begin
          e = q.pop_front();
          chk("beat_mask", 32'(m_if.m_mask), 32'(e.mask));
          chk("beat_index", 32'(m_if.m_index), 32'(e.idx));
          chk("beat_last", 32'(m_if.m_last), 32'(e.last));
        end
      end
    end
  end

  task automatic push_tab(input logic [SIZE-1:0] tab [10], input int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.mask = tab[i];
      b.idx  = CW'(i);
      b.last = (i == 9);
      q.push_back(b);
    end
  endtask

  task automatic push_one(input logic [SIZE-1:0] mk);
    beat_t b;
    b.mask = mk;
    b.idx  = '0;
    b.last = 1'b1;
    q.push_back(b);
  endtask

  task automatic run_seq(input logic [RW-1:0] rv, input int n, input bit toggle);
    int cyc;
    start   = 1'b1;
    r       = rv;
    m_if.m_ready = 1'b1;
    tick();
    start = 1'b0;
    cyc   = 1;
    while (!done && cyc < 300) begin
      m_if.m_ready = toggle ? ((cyc % 3) == 1) : 1'b1;
      tick();
      cyc++;
    end
    chk("done_seen", 32'(done), 32'd1);
    if (!toggle) chk("beat_cycles", 32'(cyc), 32'(n + 1));
    tick();
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("busy_after", 32'(busy), 32'd0);
    chk("valid_after", 32'(m_if.m_valid), 32'd0);
    chk("sb_empty", 32'(q.size()), 32'd0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_busy"},  32'(busy), 32'd0);
    chk({tag, "_valid"}, 32'(m_if.m_valid), 32'd0);
    chk({tag, "_mask"},  32'(m_if.m_mask), 32'd0);
    chk({tag, "_index"}, 32'(m_if.m_index), 32'd0);
    chk({tag, "_last"},  32'(m_if.m_last), 32'd0);
    chk({tag, "_done"},  32'(done), 32'd0);
    chk({tag, "_err"},   32'(err), 32'd0);
  endtask

  initial begin
    int k;
    rst          = 1'b1;
    start        = 1'b0;
    r            = '0;
    m_if.m_ready = 1'b0;
    tick();
    tick();
    chk_reset_state("reset");
    rst = 1'b0;
    tick();

    // r=3, ready held high
    push_tab(exp3, 10);
    run_seq(3'd3, 10, 1'b0);

    // r=0 and r=SIZE: a single beat that is also the last
    push_one(5'b00000);
    run_seq(3'd0, 1, 1'b0);
    push_one(5'b11111);
    run_seq(3'd5, 1, 1'b0);

    // r > SIZE
    start = 1'b1;
    r     = 3'd6;
    tick();
    start = 1'b0;
    chk("err_pulse", 32'(err), 32'd1);
    chk("err_valid", 32'(m_if.m_valid), 32'd0);
    chk("err_busy", 32'(busy), 32'd0);
    tick();
    chk("err_one_cycle", 32'(err), 32'd0);
    chk("err_no_done", 32'(done), 32'd0);
    chk("err_no_valid", 32'(m_if.m_valid), 32'd0);

    // r=2 with backpressure
    push_tab(exp2, 10);
    run_seq(3'd2, 10, 1'b1);

    // Mid-stream: ignored start at beat 4, reset at beat 6
    push_tab(exp3, 6);
    start        = 1'b1;
    r            = 3'd3;
    m_if.m_ready = 1'b1;
    tick();
    start = 1'b0;
    k     = 0;
    while (!(m_if.m_valid && m_if.m_index == 16'd6) && k < 50) begin
      if (m_if.m_index == 16'd4) begin
        start = 1'b1;
        r     = 3'd1;
      end else begin
        start = 1'b0;
      end
      tick();
      k++;
    end
    chk("reach_beat6", 32'(m_if.m_index), 32'd6);
    chk("beat6_mask", 32'(m_if.m_mask), 32'(exp3[6]));
    start        = 1'b0;
    rst          = 1'b1;
    m_if.m_ready = 1'b0;
    tick();
    chk_reset_state("abort");
    chk("abort_sb_empty", 32'(q.size()), 32'd0);
    rst = 1'b0;
    tick();
    chk("abort_no_done", 32'(done), 32'd0);

    push_tab(exp3, 10);
    run_seq(3'd3, 10, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
